// File: rtl/msg_schedule.sv
// msg_schedule: SHA-256 message schedule feeding the compression pipeline.
// Loads a 16-word chunk over valid/ready, then presents W[t]/K[t] for 64
// rounds (each held RND_CYCLES cycles), pulses update_o, and flags end of
// message with done_o.
// Optional macro MSG_SCHED_ERR_EN adds a sticky err_o protocol-error flag.
module msg_schedule #(
  parameter int unsigned RND_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [31:0] in_word_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic [31:0] w_o,
  output logic [31:0] k_o,
  output logic [5:0]  round_o,
  output logic        clr_no,
  output logic        update_o,
  output logic        busy_o,
  output logic        done_o
`ifdef MSG_SCHED_ERR_EN
  ,
  output logic        err_o
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, UPD, DONE} state_t;

  localparam logic [2:0] LastCyc = 3'(RND_CYCLES - 1);

  localparam logic [31:0] KTable [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_window [16];
  logic [3:0]  r_wordCnt;
  logic [2:0]  r_cyc;
  logic [5:0]  r_round;
  logic        r_lastFlag;
  logic        r_clrN;
  logic        w_accept;
  logic        w_roundEnd;
  logic [31:0] w_nextW;

  assign in_ready_o = rst_ni & ((r_state == IDLE) | (r_state == LOAD));
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_roundEnd = (r_cyc == LastCyc);
  // window[0] is W[t], so this yields W[t+16]
  assign w_nextW    = sigma1(r_window[14]) + r_window[9] + sigma0(r_window[1]) + r_window[0];

  assign w_o      = (r_state == RUN) ? r_window[0] : 32'h0;
  assign k_o      = (r_state == RUN) ? KTable[r_round] : 32'h0;
  assign round_o  = r_round;
  assign clr_no   = r_clrN;
  assign update_o = (r_state == UPD);
  assign busy_o   = (r_state != IDLE);
  assign done_o   = (r_state == DONE);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic: load 16 words, run 64 rounds, update, then next chunk or done
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_nextState = LOAD;
      LOAD: if (w_accept && (r_wordCnt == 4'd15)) w_nextState = RUN;
      RUN:  if (w_roundEnd && (r_round == 6'd63)) w_nextState = UPD;
      UPD:  if (w_roundEnd) w_nextState = r_lastFlag ? DONE : LOAD;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: word capture, round timing, and sliding-window expansion
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) r_window[i] <= 32'h0;
      r_wordCnt  <= 4'd0;
      r_cyc      <= 3'd0;
      r_round    <= 6'd0;
      r_lastFlag <= 1'b0;
      r_clrN     <= 1'b1;
    end else begin
      if (w_accept) begin
        r_window[r_wordCnt] <= in_word_i;
        r_wordCnt           <= r_wordCnt + 4'd1;
        if (r_wordCnt == 4'd15) r_lastFlag <= in_last_i;
      end
      r_clrN <= !((r_state == IDLE) && w_accept);
      if ((r_state == RUN) || (r_state == UPD)) r_cyc <= w_roundEnd ? 3'd0 : r_cyc + 3'd1;
      else                                      r_cyc <= 3'd0;
      if ((r_state == RUN) && w_roundEnd) begin
        for (int i = 0; i < 15; i++) r_window[i] <= r_window[i+1];
        r_window[15] <= w_nextW;
        r_round      <= r_round + 6'd1;
      end
    end
  end

`ifdef MSG_SCHED_ERR_EN
  logic r_err;

  assign err_o = r_err;

  // Sticky protocol error: misplaced last flag, or valid while not accepting
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_err <= 1'b0;
    else if ((w_accept && in_last_i && (r_wordCnt != 4'd15)) ||
             (in_valid_i && ((r_state == RUN) || (r_state == UPD))))
      r_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_msg_schedule.sv
// tb_msg_schedule: directed-vector bench for msg_schedule (RND_CYCLES=4).
// Covers reset, the "abc" chunk, two-chunk messages, stalled loading,
// mid-run reset and, when MSG_SCHED_ERR_EN is defined, the err_o flag.
module tb_msg_schedule;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_word_i = 32'h0;
  logic        in_last_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] w_o;
  logic [31:0] k_o;
  logic [5:0]  round_o;
  logic        clr_no;
  logic        update_o;
  logic        busy_o;
  logic        done_o;
`ifdef MSG_SCHED_ERR_EN
  logic        err_o;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] chunk [16];
  int lastOnWord = -1;

  int clrLowCount = 0;
  int updRiseCount = 0;
  int doneRiseCount = 0;
  logic prevUpd = 1'b0;
  logic prevDone = 1'b0;

  msg_schedule #(.RND_CYCLES(4)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid_i),
    .in_word_i  (in_word_i),
    .in_last_i  (in_last_i),
    .in_ready_o (in_ready_o),
    .w_o        (w_o),
    .k_o        (k_o),
    .round_o    (round_o),
    .clr_no     (clr_no),
    .update_o   (update_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef MSG_SCHED_ERR_EN
    ,
    .err_o      (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Observe pipeline controls once per cycle away from the active edge
  always @(negedge clk_i) begin
    if (!clr_no) clrLowCount++;
    if (update_o && !prevUpd) updRiseCount++;
    if (done_o && !prevDone) doneRiseCount++;
    prevUpd = update_o;
    prevDone = done_o;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic loadAbc();
    for (int i = 0; i < 16; i++) chunk[i] = 32'h0;
    chunk[0]  = 32'h61626380;
    chunk[15] = 32'h00000018;
  endtask

  // Returns on the negedge where word 15 is driven and ready is seen
  task automatic send_chunk(input logic last, input bit stall);
    for (int i = 0; i < 16; i++) begin
      int n;
      if (stall) begin
        @(negedge clk_i);
        in_valid_i = 1'b0;
      end
      @(negedge clk_i);
      in_valid_i = 1'b1;
      in_word_i  = chunk[i];
      in_last_i  = (i == 15) ? last : (i == lastOnWord);
      n = 0;
      while (!in_ready_o && n < 2000) begin
        @(negedge clk_i);
        n++;
      end
      if (n >= 2000) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL send_ready_timeout: word %0d not accepted, required in_ready_o=1", i);
      end
    end
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy_o && cycles < 700) begin
      @(negedge clk_i);
      cycles++;
    end
  endtask

  task automatic test_reset();
    logic [76:0] obs;
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    obs = {in_ready_o, busy_o, clr_no, update_o, done_o, round_o, w_o, k_o};
    testsRun++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0});
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    testsRun++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: ready=%b busy=%b expected ready=1 busy=0", in_ready_o, busy_o);
    end
  endtask

  task automatic test_abc();
    logic [31:0] expW [4] = '{32'h61626380, 32'h000f0000, 32'h7da86405, 32'h600003c6};
    int updSnap = updRiseCount;
    int doneSnap = doneRiseCount;
    int clrSnap = clrLowCount;
    loadAbc();
    send_chunk(1'b1, 1'b0);
    for (int k = 1; k <= 262; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        in_valid_i = 1'b0;
        in_last_i = 1'b0;
        testsRun++;
        if (round_o !== 6'd0 || k_o !== 32'h428a2f98 || w_o !== 32'h61626380 || in_ready_o !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL abc_round0: round=%0d k=%h w=%h ready=%b expected 0 428a2f98 61626380 0", round_o, k_o, w_o, in_ready_o);
        end
      end
      for (int t = 16; t < 20; t++) begin
        if (k == 1 + 4 * t) begin
          testsRun++;
          if (w_o !== expW[t-16] || round_o !== 6'(t)) begin
            testsFailed++;
            $display("[TB] FAIL abc_w%0d: got w=%h round=%0d expected %h round %0d", t, w_o, round_o, expW[t-16], t);
          end
        end
      end
      if (k == 253) begin
        testsRun++;
        if (k_o !== 32'hc67178f2 || round_o !== 6'd63) begin
          testsFailed++;
          $display("[TB] FAIL abc_k63: got k=%h round=%0d expected c67178f2 round 63", k_o, round_o);
        end
      end
      if (k == 256 || k == 257 || k == 260 || k == 261) begin
        testsRun++;
        if (update_o !== ((k == 257 || k == 260) ? 1'b1 : 1'b0) || (k == 257 && w_o !== 32'h0)) begin
          testsFailed++;
          $display("[TB] FAIL abc_update_timing: cycle %0d update=%b w=%h expected update=%b w=0", k, update_o, w_o, (k == 257 || k == 260));
        end
      end
      if (k == 261) begin
        testsRun++;
        if (done_o !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL abc_done: got %b expected 1", done_o);
        end
      end
      if (k == 262) begin
        testsRun++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || in_ready_o !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL abc_idle: busy=%b done=%b ready=%b expected 0 0 1", busy_o, done_o, in_ready_o);
        end
      end
    end
    testsRun++;
    if (updRiseCount - updSnap !== 1 || doneRiseCount - doneSnap !== 1 || clrLowCount - clrSnap !== 1) begin
      testsFailed++;
      $display("[TB] FAIL abc_pulse_counts: upd=%0d done=%0d clr=%0d expected 1 1 1",
               updRiseCount - updSnap, doneRiseCount - doneSnap, clrLowCount - clrSnap);
    end
  endtask

  task automatic test_two_chunk();
    int updSnap = updRiseCount;
    int doneSnap = doneRiseCount;
    int clrSnap = clrLowCount;
    int updAtDone = -1;
    int n = 0;
    loadAbc();
    send_chunk(1'b0, 1'b0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    send_chunk(1'b1, 1'b0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i = 1'b0;
    while (busy_o && n < 700) begin
      if (done_o && updAtDone < 0) updAtDone = updRiseCount - updSnap;
      @(negedge clk_i);
      n++;
    end
    testsRun++;
    if (n >= 700) begin
      testsFailed++;
      $display("[TB] FAIL two_chunk_timeout: busy still %b expected 0", busy_o);
    end
    testsRun++;
    if (clrLowCount - clrSnap !== 1) begin
      testsFailed++;
      $display("[TB] FAIL two_chunk_clr: got %0d low cycles expected 1", clrLowCount - clrSnap);
    end
    testsRun++;
    if (updRiseCount - updSnap !== 2 || doneRiseCount - doneSnap !== 1) begin
      testsFailed++;
      $display("[TB] FAIL two_chunk_pulses: upd=%0d done=%0d expected 2 1", updRiseCount - updSnap, doneRiseCount - doneSnap);
    end
    testsRun++;
    if (updAtDone !== 2) begin
      testsFailed++;
      $display("[TB] FAIL two_chunk_done_order: updates before done=%0d expected 2", updAtDone);
    end
  endtask

  task automatic test_stall_load();
    logic [31:0] expWords [16];
    int cycles;
    for (int i = 0; i < 16; i++) begin
      expWords[i] = 32'hA5000000 | (32'(i) * 32'h00010203);
      chunk[i] = expWords[i];
    end
    send_chunk(1'b1, 1'b1);
    testsRun++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL stall_still_loading: ready=%b busy=%b expected 1 1", in_ready_o, busy_o);
    end
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        in_valid_i = 1'b0;
        in_last_i = 1'b0;
      end
      if ((k - 1) % 4 == 0) begin
        testsRun++;
        if (w_o !== expWords[(k-1)/4] || round_o !== 6'((k-1)/4)) begin
          testsFailed++;
          $display("[TB] FAIL stall_word%0d: got w=%h round=%0d expected %h", (k-1)/4, w_o, round_o, expWords[(k-1)/4]);
        end
      end
    end
    waitIdle(cycles);
    testsRun++;
    if (cycles >= 700) begin
      testsFailed++;
      $display("[TB] FAIL stall_idle_timeout: busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [76:0] obs;
    int updSnap = updRiseCount;
    int doneSnap = doneRiseCount;
    loadAbc();
    send_chunk(1'b1, 1'b0);
    for (int k = 1; k <= 121; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        in_valid_i = 1'b0;
        in_last_i = 1'b0;
      end
    end
    testsRun++;
    if (round_o !== 6'd30) begin
      testsFailed++;
      $display("[TB] FAIL midreset_round: got %0d expected 30", round_o);
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    obs = {in_ready_o, busy_o, clr_no, update_o, done_o, round_o, w_o, k_o};
    testsRun++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0}) begin
      testsFailed++;
      $display("[TB] FAIL midreset_outputs: got %h expected %h", obs, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0});
    end
    rst_ni = 1'b1;
    repeat (300) @(negedge clk_i);
    testsRun++;
    if (updRiseCount - updSnap !== 0 || doneRiseCount - doneSnap !== 0 || busy_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_no_pulses: upd=%0d done=%0d busy=%b expected 0 0 0",
               updRiseCount - updSnap, doneRiseCount - doneSnap, busy_o);
    end
    test_abc();
  endtask

`ifdef MSG_SCHED_ERR_EN
  task automatic test_err();
    int cycles;
    int doneSnap;
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    testsRun++;
    if (err_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL err_reset: got %b expected 0", err_o);
    end
    doneSnap = doneRiseCount;
    loadAbc();
    lastOnWord = 7;
    send_chunk(1'b1, 1'b0);
    lastOnWord = -1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i = 1'b0;
    testsRun++;
    if (err_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL err_last_word7: got %b expected 1", err_o);
    end
    waitIdle(cycles);
    testsRun++;
    if (err_o !== 1'b1 || doneRiseCount - doneSnap !== 1 || cycles >= 700) begin
      testsFailed++;
      $display("[TB] FAIL err_sticky_flow: err=%b done=%0d expected err 1 done 1", err_o, doneRiseCount - doneSnap);
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    send_chunk(1'b1, 1'b0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_last_i = 1'b0;
    repeat (5) @(negedge clk_i);
    testsRun++;
    if (err_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL err_clean_run: got %b expected 0", err_o);
    end
    in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    testsRun++;
    if (err_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL err_valid_in_run: got %b expected 1", err_o);
    end
    waitIdle(cycles);
  endtask
`endif

  initial begin
    test_reset();
    test_abc();
    test_two_chunk();
    test_stall_load();
    test_reset_mid();
`ifdef MSG_SCHED_ERR_EN
    test_err();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
